uart_tx_fifo: RTL and testbench

Parametrised UART transmit channel with an integrated write FIFO, runtime-selectable frame format (5–8 data bits, parity mode, 1/2 stop bits) and an integrated baud divider. It sits between the register/host side of the UART SoC and the `tx` pin. It replaces the fixed 8-bit, FIFO-less transmit path with a single-clock, buffered, back-pressured transmitter.

---
 rtl/uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a write FIFO, runtime frame
// format (5-8 data bits, none/odd/even/stick parity, 1/2 stop bits) and a
// per-frame latched baud divisor. Optional line break: define UART_TX_BREAK_EN.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   lcr,
   input  logic [DIV_W-1:0]             div,
   input  logic                         wr_en,
   input  logic [7:0]                   din,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  count,
   output logic                         overflow,
   output logic                         busy,
   output logic                         tx
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic             full_r, empty_r, overflow_r;
   logic             push_s, pop_s;
   state_t           state_r, state_nxt_s;
   logic [DIV_W-1:0] baud_r, baud_nxt_s, div_lat_r, div_nxt_s;
   logic [2:0]       idx_r, idx_nxt_s;
   logic [7:0]       data_r, data_nxt_s;
   logic [5:0]       lcr_lat_r, lcr_nxt_s;
   logic             tick_s, last_data_s, last_stop_s;
   logic             tx_nxt_s, tx_r, busy_r;
   logic             lcr_unused_s;

   // Parity bit for the active word length: data XOR, its inverse, or stick value.
   function automatic logic parity_bit(input logic [7:0] d, input logic [5:0] l);
      logic [7:0] mask;
      logic       x;
      case (l[1:0])
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      x = ^(d & mask);
      if (l[5]) begin
         parity_bit = ~l[4];
      end else if (l[4]) begin
         parity_bit = x;
      end else begin
         parity_bit = ~x;
      end
   endfunction

   // Bit 7 is never used; bit 6 only when break support is compiled in.
   assign lcr_unused_s = ^lcr[7:6];

   assign push_s      = wr_en & ~full_r;
   assign tick_s      = (baud_r == div_lat_r);
   assign last_data_s = (idx_r == (3'd4 + {1'b0, lcr_lat_r[1:0]}));
   assign last_stop_s = (idx_r == {2'b00, lcr_lat_r[2]});

   // Next FIFO occupancy; a simultaneous push and pop cancel out.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO storage; entries need no reset because occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // FIFO pointers, flags and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
         empty_r <= (count_nxt_s == {CNT_W{1'b0}});
         if (wr_en && full_r) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame sequencer: next state, baud/bit counters and pop/latch decisions.
   always_comb begin
      state_nxt_s = state_r;
      baud_nxt_s  = baud_r + DIV_W'(1);
      idx_nxt_s   = idx_r;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            baud_nxt_s = baud_r;
            if (!empty_r) begin
               pop_s       = 1'b1;
               state_nxt_s = START;
               baud_nxt_s  = {DIV_W{1'b0}};
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               state_nxt_s = DATA;
               baud_nxt_s  = {DIV_W{1'b0}};
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (tick_s) begin
               baud_nxt_s = {DIV_W{1'b0}};
               if (last_data_s) begin
                  idx_nxt_s   = 3'd0;
                  state_nxt_s = lcr_lat_r[3] ? PARITY : STOP;
               end else begin
                  idx_nxt_s = idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = DATA;
            end
         end
         PARITY: begin
            if (tick_s) begin
               state_nxt_s = STOP;
               baud_nxt_s  = {DIV_W{1'b0}};
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = PARITY;
            end
         end
         STOP: begin
            if (tick_s) begin
               baud_nxt_s = {DIV_W{1'b0}};
               if (last_stop_s) begin
                  idx_nxt_s = 3'd0;
                  if (!empty_r) begin
                     pop_s       = 1'b1;
                     state_nxt_s = START;
                  end else begin
                     state_nxt_s = IDLE;
                  end
               end else begin
                  idx_nxt_s = idx_r + 3'd1;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            baud_nxt_s  = {DIV_W{1'b0}};
            idx_nxt_s   = 3'd0;
         end
      endcase
   end

   // Frame context is captured only when a byte is popped.
   always_comb begin
      data_nxt_s = data_r;
      lcr_nxt_s  = lcr_lat_r;
      div_nxt_s  = div_lat_r;
      if (pop_s) begin
         data_nxt_s = mem_r[rd_ptr_r];
         lcr_nxt_s  = lcr[5:0];
         div_nxt_s  = div;
      end else begin
         data_nxt_s = data_r;
      end
   end

   // Line level for the upcoming cycle, so tx can be a plain register.
   always_comb begin
      tx_nxt_s = 1'b1;
      case (state_nxt_s)
         IDLE:    tx_nxt_s = 1'b1;
         START:   tx_nxt_s = 1'b0;
         DATA:    tx_nxt_s = data_nxt_s[idx_nxt_s];
         PARITY:  tx_nxt_s = parity_bit(data_nxt_s, lcr_nxt_s);
         STOP:    tx_nxt_s = 1'b1;
         default: tx_nxt_s = 1'b1;
      endcase
   end

   // Sequencer registers plus registered busy and tx outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         baud_r    <= {DIV_W{1'b0}};
         idx_r     <= 3'd0;
         data_r    <= 8'h00;
         lcr_lat_r <= 6'h00;
         div_lat_r <= {DIV_W{1'b0}};
         busy_r    <= 1'b0;
         tx_r      <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         baud_r    <= baud_nxt_s;
         idx_r     <= idx_nxt_s;
         data_r    <= data_nxt_s;
         lcr_lat_r <= lcr_nxt_s;
         div_lat_r <= div_nxt_s;
         busy_r    <= (state_nxt_s != IDLE);
`ifdef UART_TX_BREAK_EN
         tx_r      <= lcr[6] ? 1'b0 : tx_nxt_s;
`else
         tx_r      <= tx_nxt_s;
`endif
      end
   end

   assign full     = full_r;
   assign empty    = empty_r;
   assign count    = count_r;
   assign overflow = overflow_r;
   assign busy     = busy_r;
   assign tx       = tx_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed test-plan sequences plus random traffic,
// checked every cycle against a queue-based model of FIFO and line waveform.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       lcr;
   logic [DIV_W-1:0] div;
   logic             wr_en;
   logic [7:0]       din;
   logic             full, empty, overflow, busy, tx;
   logic [4:0]       count;

   uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .lcr(lcr), .div(div), .wr_en(wr_en), .din(din),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .busy(busy), .tx(tx)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           failures = 0;
   int           busy_hi = 0;
   byte unsigned fifo_q[$];
   bit           line_q[$];
   bit           ovf_m = 1'b0;

   // Single comparison point: counts and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Append the per-cycle line levels of one frame to the expected waveform.
   task automatic add_frame(input logic [7:0] d, input logic [7:0] l, input int dv);
      int n;
      bit p;
      bit bits[$];
      n = 5 + int'(l[1:0]);
      p = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (l[3]) begin
         if (l[5]) bits.push_back(~l[4]);
         else if (l[4]) bits.push_back(p);
         else bits.push_back(~p);
      end
      bits.push_back(1'b1);
      if (l[2]) bits.push_back(1'b1);
      foreach (bits[b])
         for (int c = 0; c <= dv; c++) line_q.push_back(bits[b]);
   endtask

   // Model of one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int pre;
      if (rst) begin
         fifo_q.delete();
         line_q.delete();
         ovf_m = 1'b0;
      end else begin
         pre = fifo_q.size();
         if (line_q.size() > 0) line_q.delete(0);
         if (line_q.size() == 0 && pre > 0) add_frame(fifo_q.pop_front(), lcr, int'(div));
         if (wr_en) begin
            if (pre < DEPTH) fifo_q.push_back(din);
            else ovf_m = 1'b1;
         end
      end
   endtask

   // One clock: drive, advance model at the edge, compare all outputs after it.
   task automatic cycle(input logic r, input logic w, input logic [7:0] d);
      logic exp_tx;
      rst = r; wr_en = w; din = d;
      @(posedge clk);
      model_edge();
      #1;
      exp_tx = (line_q.size() > 0) ? line_q[0] : 1'b1;
`ifdef UART_TX_BREAK_EN
      if (!r && lcr[6]) exp_tx = 1'b0;
`endif
      check_eq("tx", tx, exp_tx);
      check_eq("busy", busy, line_q.size() > 0);
      check_eq("count", count, fifo_q.size());
      check_eq("full", full, fifo_q.size() == DEPTH);
      check_eq("empty", empty, fifo_q.size() == 0);
      check_eq("overflow", overflow, ovf_m);
      busy_hi += int'(busy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
   endtask

   logic [39:0] tx_cap;
   logic [39:0] tx_exp;
   logic [0:9]  pat;

   initial begin
      rst = 1'b1; wr_en = 1'b0; din = 8'h00; lcr = 8'h00; div = '0;
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_empty", empty, 1'b1);
      check_eq("rst_count", count, 5'd0);

      // 8N1, div=3, byte A5: known 40-cycle waveform and busy length
      lcr = 8'h03; div = 16'd3; busy_hi = 0;
      cycle(1'b0, 1'b1, 8'hA5);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b0, 8'h00);
         tx_cap[39-i] = tx;
      end
      idle(5);
      pat = 10'b0101001011;
      for (int b = 0; b < 10; b++)
         for (int c = 0; c < 4; c++) tx_exp[39-(b*4+c)] = pat[b];
      check_eq("8n1_wave_hi", tx_cap[39:20], tx_exp[39:20]);
      check_eq("8n1_wave_lo", tx_cap[19:0], tx_exp[19:0]);
      check_eq("8n1_busy_len", busy_hi, 40);

      // parity modes on 7-bit 0x7F, div=0, 2 stop bits
      div = 16'd0;
      lcr = 8'h1E; cycle(1'b0, 1'b1, 8'h7F); idle(14);
      lcr = 8'h0E; cycle(1'b0, 1'b1, 8'h7F); idle(14);
      lcr = 8'h3E; cycle(1'b0, 1'b1, 8'h7F); idle(14);

      // back-to-back 5N1 frames, div=1: 28 busy cycles without a gap
      lcr = 8'h00; div = 16'd1; busy_hi = 0;
      cycle(1'b0, 1'b1, 8'h1F);
      cycle(1'b0, 1'b1, 8'h00);
      idle(32);
      check_eq("b2b_busy_len", busy_hi, 28);

      // FIFO fill and overflow at div=100; later frames latch div=0 to drain fast
      lcr = 8'h03; div = 16'd100;
      for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1, 8'(i + 1));
      check_eq("fill_full", full, 1'b1);
      check_eq("fill_ovf", overflow, 1'b1);
      div = 16'd0;
      idle(1300);
      check_eq("fill_drained", empty, 1'b1);

      // reset in the middle of the data bits, then a clean frame
      cycle(1'b1, 1'b0, 8'h00);
      lcr = 8'h03; div = 16'd3;
      cycle(1'b0, 1'b1, 8'h55);
      idle(10);
      cycle(1'b1, 1'b0, 8'h00);
      check_eq("midrst_tx", tx, 1'b1);
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_count", count, 5'd0);
      cycle(1'b0, 1'b1, 8'hC3);
      idle(45);

`ifdef UART_TX_BREAK_EN
      // break forces the line low mid-frame while the sequencer keeps running
      cycle(1'b0, 1'b1, 8'hFF);
      idle(12);
      lcr = 8'h43;
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("brk_low", tx, 1'b0);
      idle(3);
      lcr = 8'h03;
      idle(40);
`endif

      // random traffic with occasional format changes and resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            lcr = 8'($urandom_range(0, 255));
            lcr[6] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 31) == 0) div = DIV_W'($urandom_range(0, 3));
         cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
      end
      lcr = 8'h00;
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
